// File: rtl/s38584_chan_scan_mon.sv
// ---------------------------------------------------------------------------
// s38584_chan_scan_mon
//
// Purpose:
//   Round-robin channel scan monitor. On an accepted start it snapshots the
//   phase select, the tag compare and the gating term. It then visits one
//   channel per cycle and accumulates the per-channel hits. One cycle later it
//   registers a combined status flag. Each flagged scan bumps a saturating
//   mismatch counter.
//
// Optional feature (macro S38584_CHAN_SCAN_PARITY_EN):
//   When defined, adds the output hit_par. It is the XOR of every per-channel
//   hit bit seen during the last scan, registered together with flag.
//
// Ports:
//   CK          in   clock, rising edge
//   RN          in   asynchronous active-low reset
//   start       in   scan request, only honoured while idle
//   sel_phase   in   0: even channels eligible, 1: odd channels eligible
//   tag_in      in   [TAG_W] observed tag
//   tag_ref     in   [TAG_W] reference tag
//   ch_req      in   [NCH] per-channel request flags (sampled live)
//   ch_busy     in   [NCH] per-channel busy flags; a busy channel is masked
//   gate_a..d   in   gating terms, gate = gate_c & ((gate_a & gate_b) | gate_d)
//   busy        out  high while a scan/evaluation is in progress
//   cur_ch      out  [log2(NCH)] channel currently being scanned
//   flag        out  registered status result
//   flag_valid  out  one-cycle pulse when flag updates
//   mis_cnt     out  [CNT_W] saturating count of scans that produced flag=1
//   done        out  one-cycle pulse at scan end, coincident with flag_valid
//   hit_par     out  (macro only) parity of hits from the last scan
// ---------------------------------------------------------------------------
module s38584_chan_scan_mon #(
    parameter int NCH   = 8,
    parameter int TAG_W = 2,
    parameter int CNT_W = 4
) (
    input  logic                   CK,
    input  logic                   RN,
    input  logic                   start,
    input  logic                   sel_phase,
    input  logic [TAG_W-1:0]       tag_in,
    input  logic [TAG_W-1:0]       tag_ref,
    input  logic [NCH-1:0]         ch_req,
    input  logic [NCH-1:0]         ch_busy,
    input  logic                   gate_a,
    input  logic                   gate_b,
    input  logic                   gate_c,
    input  logic                   gate_d,
    output logic                   busy,
    output logic [$clog2(NCH)-1:0] cur_ch,
    output logic                   flag,
    output logic                   flag_valid,
    output logic [CNT_W-1:0]       mis_cnt,
`ifdef S38584_CHAN_SCAN_PARITY_EN
    output logic                   hit_par,
`endif
    output logic                   done
);

    localparam int CH_W = $clog2(NCH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_EVAL = 2'd2;

    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NCH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_reg;
    logic [CH_W-1:0]  cur_ch_reg;
    logic             phase_reg;
    logic             tag_ok_reg;
    logic             gate_reg;
    logic             hit_acc_reg;
    logic             flag_reg;
    logic             flag_valid_reg;
    logic             done_reg;
    logic [CNT_W-1:0] mis_cnt_reg;
`ifdef S38584_CHAN_SCAN_PARITY_EN
    logic             par_acc_reg;
    logic             hit_par_reg;
`endif

    logic             gate_now;
    logic [NCH-1:0]   hit_vec;
    logic             hit_cur;
    logic             flag_next;

    assign gate_now = gate_c & ((gate_a & gate_b) | gate_d);

    // Hit candidates for every channel. Only the channel under cur_ch is
    // consumed, so ch_req/ch_busy are effectively sampled live in that cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_hit
            localparam logic ODD_CH = ((gi % 2) != 0);
            assign hit_vec[gi] = ch_req[gi] & ~ch_busy[gi] & (phase_reg == ODD_CH);
        end
    endgenerate

    assign hit_cur   = hit_vec[cur_ch_reg];
    assign flag_next = hit_acc_reg ^ (tag_ok_reg & gate_reg);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_reg      <= ST_IDLE;
            cur_ch_reg     <= '0;
            phase_reg      <= 1'b0;
            tag_ok_reg     <= 1'b0;
            gate_reg       <= 1'b0;
            hit_acc_reg    <= 1'b0;
            flag_reg       <= 1'b0;
            flag_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            mis_cnt_reg    <= '0;
`ifdef S38584_CHAN_SCAN_PARITY_EN
            par_acc_reg    <= 1'b0;
            hit_par_reg    <= 1'b0;
`endif
        end else begin
            // Pulses default low; they are raised only on the EVAL edge.
            flag_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg   <= ST_SCAN;
                        cur_ch_reg  <= '0;
                        phase_reg   <= sel_phase;
                        tag_ok_reg  <= (tag_in == tag_ref);
                        gate_reg    <= gate_now;
                        hit_acc_reg <= 1'b0;
`ifdef S38584_CHAN_SCAN_PARITY_EN
                        par_acc_reg <= 1'b0;
`endif
                    end
                end
                ST_SCAN: begin
                    hit_acc_reg <= hit_acc_reg | hit_cur;
`ifdef S38584_CHAN_SCAN_PARITY_EN
                    par_acc_reg <= par_acc_reg ^ hit_cur;
`endif
                    // NCH is a power of two, so the increment wraps to 0
                    // exactly when leaving the last channel.
                    cur_ch_reg  <= cur_ch_reg + CH_W'(1);
                    if (cur_ch_reg == LAST_CH) begin
                        state_reg <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    flag_reg       <= flag_next;
                    flag_valid_reg <= 1'b1;
                    done_reg       <= 1'b1;
`ifdef S38584_CHAN_SCAN_PARITY_EN
                    hit_par_reg    <= par_acc_reg;
`endif
                    if (flag_next && (mis_cnt_reg != CNT_MAX)) begin
                        mis_cnt_reg <= mis_cnt_reg + CNT_W'(1);
                    end
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = (state_reg != ST_IDLE);
    assign cur_ch     = cur_ch_reg;
    assign flag       = flag_reg;
    assign flag_valid = flag_valid_reg;
    assign done       = done_reg;
    assign mis_cnt    = mis_cnt_reg;
`ifdef S38584_CHAN_SCAN_PARITY_EN
    assign hit_par    = hit_par_reg;
`endif

endmodule

// File: tb/tb_s38584_chan_scan_mon.sv
// ---------------------------------------------------------------------------
// tb_s38584_chan_scan_mon
//
// Scoreboard bench for s38584_chan_scan_mon (NCH=8, TAG_W=2, CNT_W=4).
// The driver issues scans and pushes the expected result of each scan, which
// it derives from the channel rules directly. A separate monitor pops and
// compares whenever done/flag_valid pulse. Define S38584_CHAN_SCAN_PARITY_EN
// to also connect and check hit_par.
// ---------------------------------------------------------------------------
module tb_s38584_chan_scan_mon;

    localparam int NCH   = 8;
    localparam int TAG_W = 2;
    localparam int CNT_W = 4;
    localparam int CH_W  = 3;
    localparam int SAT   = 15;

    logic             CK = 1'b0;
    logic             RN;
    logic             start;
    logic             sel_phase;
    logic [TAG_W-1:0] tag_in;
    logic [TAG_W-1:0] tag_ref;
    logic [NCH-1:0]   ch_req;
    logic [NCH-1:0]   ch_busy;
    logic             gate_a, gate_b, gate_c, gate_d;
    logic             busy;
    logic [CH_W-1:0]  cur_ch;
    logic             flag;
    logic             flag_valid;
    logic [CNT_W-1:0] mis_cnt;
    logic             done;
`ifdef S38584_CHAN_SCAN_PARITY_EN
    logic             hit_par;
`endif

    s38584_chan_scan_mon #(.NCH(NCH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .CK         (CK),
        .RN         (RN),
        .start      (start),
        .sel_phase  (sel_phase),
        .tag_in     (tag_in),
        .tag_ref    (tag_ref),
        .ch_req     (ch_req),
        .ch_busy    (ch_busy),
        .gate_a     (gate_a),
        .gate_b     (gate_b),
        .gate_c     (gate_c),
        .gate_d     (gate_d),
        .busy       (busy),
        .cur_ch     (cur_ch),
        .flag       (flag),
        .flag_valid (flag_valid),
        .mis_cnt    (mis_cnt),
`ifdef S38584_CHAN_SCAN_PARITY_EN
        .hit_par    (hit_par),
`endif
        .done       (done)
    );

    always #5 CK = ~CK;

    typedef struct {
        logic             flag;
        logic [CNT_W-1:0] mis;
        logic             par;
        int               cyc;
    } exp_t;

    exp_t           sb[$];
    int             errors = 0;
    int             checks = 0;
    int             cyc    = 0;
    int             mis_model = 0;
    logic [NCH-1:0] req_seq[NCH];
    logic [NCH-1:0] bsy_seq[NCH];

    always @(posedge CK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one line per completed scan, compared against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CK);
            if (flag_valid || done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: done=%0b flag_valid=%0b, expected no pulse", done, flag_valid);
                end else begin
                    e = sb.pop_front();
                    $display("scan done @cyc %0d: flag=%0b mis_cnt=%0d (exp flag=%0b mis=%0d)",
                             cyc, flag, mis_cnt, e.flag, e.mis);
                    chk("flag", 32'(flag), 32'(e.flag));
                    chk("mis_cnt", 32'(mis_cnt), 32'(e.mis));
                    chk("done_and_valid", 32'({done, flag_valid}), 32'h3);
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("busy_at_done", 32'(busy), 32'h0);
`ifdef S38584_CHAN_SCAN_PARITY_EN
                    chk("hit_par", 32'(hit_par), 32'(e.par));
`endif
                end
            end
        end
    end

    task automatic fill_const(input logic [NCH-1:0] r, input logic [NCH-1:0] b);
        for (int k = 0; k < NCH; k++) begin
            req_seq[k] = r;
            bsy_seq[k] = b;
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < NCH; k++) begin
            req_seq[k] = NCH'($urandom);
            bsy_seq[k] = NCH'($urandom);
        end
    endtask

    // Entered at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic do_scan(input logic ph, input logic [TAG_W-1:0] ti, input logic [TAG_W-1:0] tr,
                           input logic ga, input logic gb, input logic gc, input logic gd);
        int   acc;
        logic hit, par, f;
        exp_t e;
        start = 1'b1; sel_phase = ph; tag_in = ti; tag_ref = tr;
        gate_a = ga; gate_b = gb; gate_c = gc; gate_d = gd;
        ch_req = NCH'($urandom); ch_busy = NCH'($urandom);
        @(posedge CK);
        @(negedge CK);
        acc = cyc;
        for (int k = 0; k < NCH; k++) begin
            ch_req  = req_seq[k];
            ch_busy = bsy_seq[k];
            // Scan-time noise on captured inputs and start; all must be ignored.
            start     = 1'($urandom_range(0, 1));
            sel_phase = 1'($urandom);
            tag_in    = TAG_W'($urandom);
            tag_ref   = TAG_W'($urandom);
            gate_a = 1'($urandom); gate_b = 1'($urandom);
            gate_c = 1'($urandom); gate_d = 1'($urandom);
            chk("cur_ch", 32'(cur_ch), 32'(k));
            chk("busy_scan", 32'(busy), 32'h1);
            @(posedge CK);
            @(negedge CK);
        end
        hit = 1'b0;
        par = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            logic h;
            h   = req_seq[k][k] & ~bsy_seq[k][k] & ((k % 2) == int'(ph));
            hit = hit | h;
            par = par ^ h;
        end
        f = hit ^ ((ti == tr) & (gc & ((ga & gb) | gd)));
        if (f) mis_model = (mis_model + 1 > SAT) ? SAT : mis_model + 1;
        e.flag = f;
        e.mis  = CNT_W'(mis_model);
        e.par  = par;
        e.cyc  = acc + NCH + 1;
        sb.push_back(e);
        start = 1'($urandom_range(0, 1));
        @(posedge CK);
        @(negedge CK);
        start = 1'b0;
    endtask

    initial begin
        RN = 1'b0; start = 1'b0; sel_phase = 1'b0; tag_in = '0; tag_ref = '0;
        ch_req = '0; ch_busy = '0; gate_a = 0; gate_b = 0; gate_c = 0; gate_d = 0;
        repeat (2) @(negedge CK);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cur_ch", 32'(cur_ch), 0);
        chk("rst_flag", 32'(flag), 0);
        chk("rst_flag_valid", 32'(flag_valid), 0);
        chk("rst_mis_cnt", 32'(mis_cnt), 0);
        chk("rst_done", 32'(done), 0);
`ifdef S38584_CHAN_SCAN_PARITY_EN
        chk("rst_hit_par", 32'(hit_par), 0);
`endif
        RN = 1'b1;
        @(negedge CK);

        // Phase select: channel 1 only eligible in odd phase.
        fill_const(8'h02, 8'h00);
        do_scan(1'b0, 2'b01, 2'b10, 0, 0, 0, 0);
        do_scan(1'b1, 2'b01, 2'b10, 0, 0, 0, 0);
        // XOR path: hit on ch0 cancelled by tag_ok & gate, restored with gate_c=0.
        fill_const(8'h01, 8'h00);
        do_scan(1'b0, 2'b10, 2'b10, 1, 1, 1, 0);
        do_scan(1'b0, 2'b10, 2'b10, 1, 1, 0, 0);
        // Busy masking, then live release of ch_busy[4] in its own cycle.
        fill_const(8'hFF, 8'hFF);
        do_scan(1'b0, 2'b01, 2'b10, 0, 0, 0, 0);
        bsy_seq[4] = 8'hEF;
        do_scan(1'b0, 2'b01, 2'b10, 0, 0, 0, 0);
        // Parity patterns: two even hits, then three even hits.
        fill_const(8'h05, 8'h00);
        do_scan(1'b0, 2'b01, 2'b10, 0, 0, 0, 0);
        fill_const(8'h15, 8'h00);
        do_scan(1'b0, 2'b01, 2'b10, 0, 0, 0, 0);
        // Saturation: 20 flagged scans back to back.
        fill_const(8'hFF, 8'h00);
        for (int n = 0; n < 20; n++) do_scan(1'b0, 2'b00, 2'b11, 0, 0, 0, 0);

        // Reset mid-scan at cur_ch=3.
        start = 1'b1; sel_phase = 1'b0; ch_req = 8'hFF; ch_busy = 8'h00;
        @(posedge CK);
        @(negedge CK);
        start = 1'b0;
        repeat (3) begin
            @(posedge CK);
            @(negedge CK);
        end
        chk("abort_cur_ch", 32'(cur_ch), 32'd3);
        RN = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_cur_ch0", 32'(cur_ch), 0);
        chk("abort_flag", 32'(flag), 0);
        chk("abort_flag_valid", 32'(flag_valid), 0);
        chk("abort_mis_cnt", 32'(mis_cnt), 0);
        chk("abort_done", 32'(done), 0);
        mis_model = 0;
        repeat (8) @(negedge CK);
        RN = 1'b1;
        do_scan(1'b0, 2'b00, 2'b11, 0, 0, 0, 0);

        // Randomized scans.
        for (int n = 0; n < 30; n++) begin
            fill_rand();
            do_scan(1'($urandom), TAG_W'($urandom), TAG_W'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (4) @(negedge CK);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/s38584_chan_scan_mon.md
Name: s38584_chan_scan_mon

Overview:
- Sequential, parametrised successor to the s38584 flag-select cone.
- Scans NCH channel request/busy pairs round-robin under a phase select, and evaluates a tag-compare decode against a gating term.
- Produces a registered combined status flag, a saturating mismatch counter and a done pulse per scan.
- Sits beside the channel state registers and feeds the control-unit status path.

Parameters:
- NCH, 8, number of channels; power of two, minimum 2.
- TAG_W, 2, width of tag_in / tag_ref compare.
- CNT_W, 4, width of the saturating mismatch counter.

Ports:
- CK  input  1  clock, rising edge.
- RN  input  1  reset; asynchronous, active-low.
- start  input  1  request a scan; sampled in IDLE only.
- sel_phase  input  1  phase select. 0: even-indexed channels eligible. 1: odd-indexed channels eligible.
- tag_in  input  TAG_W  observed tag.
- tag_ref  input  TAG_W  reference tag.
- ch_req  input  NCH  per-channel request flags.
- ch_busy  input  NCH  per-channel busy flags; a busy channel is masked.
- gate_a, gate_b, gate_c, gate_d  input  1 each  gating terms. gate = gate_c & ((gate_a & gate_b) | gate_d).
- busy  output  1  high while the FSM is not in IDLE.
- cur_ch  output  log2(NCH)  channel index currently being scanned.
- flag  output  1  registered status result.
- flag_valid  output  1  one-cycle pulse when flag updates.
- mis_cnt  output  CNT_W  saturating count of scans with flag=1.
- done  output  1  one-cycle pulse at scan end; coincident with flag_valid.

Behaviour:
- Reset (RN low, async): FSM=IDLE; busy=0, cur_ch=0, flag=0, flag_valid=0, mis_cnt=0, done=0; internal latches cleared.
- Reset mid-scan aborts the scan. No flag_valid is issued. Operation restarts from IDLE after RN rises.
- FSM states: IDLE, SCAN, EVAL.
  - IDLE -> SCAN when start=1.
  - On that edge: latch phase_q=sel_phase, tag_ok_q=(tag_in==tag_ref), gate_q=gate. Clear hit_acc; set cur_ch=0.
  - SCAN: one channel per cycle, cur_ch = 0..NCH-1.
    - Channel i hits if ch_req[i] & ~ch_busy[i] & (i[0]==phase_q).
    - hit_acc |= hit(i).
    - ch_req/ch_busy are sampled live in the cycle cur_ch=i.
  - SCAN -> EVAL after cur_ch=NCH-1. cur_ch wraps to 0.
  - EVAL (one cycle):
    - flag <= hit_acc XOR (tag_ok_q & gate_q).
    - flag_valid=1 and done=1 for exactly this cycle.
    - If the new flag=1, mis_cnt increments, saturating at 2^CNT_W-1 (never wraps).
    - EVAL -> IDLE.
- Scan latency: start accepted at edge T; SCAN occupies NCH cycles; flag/done visible after edge T+NCH+1.
- start while busy=1 is ignored; it is not queued.
- start held high continuously gives back-to-back scans with exactly one IDLE cycle between them.
- tag_in, tag_ref, sel_phase and gate inputs changing after the accept edge have no effect on that scan.
- flag holds its value between evaluations. mis_cnt clears only on reset.

Optional Feature:
- Macro: S38584_CHAN_SCAN_PARITY_EN.
- Defined: adds output hit_par (1 bit), reset value 0. It is the XOR of all per-channel hit bits from the last scan, registered in EVAL alongside flag.
- Not defined: port and logic absent; all other behaviour unchanged.

Test Plan:
- Reset mid-scan: NCH=8, start, drop RN at cur_ch=3 -> all outputs 0 immediately; no done pulse; the next start performs a full 8-cycle scan.
- Phase select: sel_phase=0, ch_req=8'b0000_0010, ch_busy=0, tag_in!=tag_ref -> flag=0. Repeat with sel_phase=1 -> flag=1, mis_cnt=1; done exactly 9 cycles after the accept edge.
- XOR path: ch_req=8'h01, sel_phase=0, tag_in=tag_ref=2'b10, gate_c=1, gate_a=gate_b=1 -> flag=0 (1 XOR 1). Set gate_c=0 -> flag=1.
- Busy masking and live sampling: ch_req=8'hFF, ch_busy=8'hFF -> no hit. Deassert ch_busy[4] during cycle cur_ch=4 with sel_phase=0 -> flag=1.
- Saturation: CNT_W=4, 20 consecutive scans with flag=1 -> mis_cnt stops at 15. start held high -> one IDLE cycle between done pulses; start pulses while busy are ignored.
- Parity (macro on): sel_phase=0, ch_req=8'h05, ch_busy=0 -> hit_par=0. ch_req=8'h15 -> hit_par=1.
